ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder backed by an internal byte-lane SRAM; drives slave rdata/readyout/resp into the response multiplexor.
//  Selected by the address decoder via ahb_sel_in; supports configurable wait states, pipelined transfers and 2-cycle ERROR.
//  Reference target for bring-up of decoder/multiplexor paths and for bus error handling.
// PARAMETERS
//  AHB_ADDR_WIDTH  32  width of ahb_addr_in
//  AHB_DATA_WIDTH  32  data bus width; 32 or 64
//  MEM_DEPTH       64  number of AHB_DATA_WIDTH words in SRAM; power of 2
//  WAIT_STATES     1   readyout-low cycles inserted per OKAY read/write data phase (0..15)
// PORTS
//  ahb_clk_in      in   1               bus clock, all logic on rising edge
//  ahb_rst_in      in   1               synchronous reset, active-high
//  ahb_sel_in      in   1               decoder select for this slave
//  ahb_addr_in     in   AHB_ADDR_WIDTH  address phase address (offset; upper bits ignored beyond window)
//  ahb_trans_in    in   2               HTRANS: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  ahb_write_in    in   1               1 = write, 0 = read
//  ahb_size_in     in   3               HSIZE: 0 byte, 1 half, 2 word, 3 dword
//  ahb_wdata_in    in   AHB_DATA_WIDTH  write data, valid in data phase
//  ahb_ready_in    in   1               bus HREADY from multiplexor (previous transfer completing)
//  ahb_rdata_out   out  AHB_DATA_WIDTH  read data, valid when readyout=1 in read data phase
//  ahb_readyout_out out 1               slave HREADYOUT
//  ahb_resp_out    out  1               0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (ahb_rst_in=1 at edge): rdata_out=0, readyout_out=1, resp_out=0, FSM=IDLE, wait counter=0; SRAM contents not reset.
//  Reset mid-transfer: transfer abandoned; pending write NOT committed; next cycle responds as IDLE.
//  Address phase accepted when sel_in & ready_in & trans_in[1]; addr/write/size/lanes registered.
//  IDLE/BUSY or sel_in=0 with ready_in=1: no transfer; next cycle readyout=1, resp=0 (zero-wait OKAY).
//  ready_in=0: address phase signals ignored (held by master), no capture.
//  Error checks at capture (any -> ERROR): size > log2(AHB_DATA_WIDTH/8); addr not aligned to size;
//   addr >= MEM_DEPTH*AHB_DATA_WIDTH/8. Errored writes do not modify SRAM.
//  FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   IDLE -> WAIT (accepted OK, WAIT_STATES>0, counter loaded WAIT_STATES-1); -> DATA (accepted OK, WAIT_STATES=0);
//   IDLE -> ERR1 (accepted, error). WAIT: readyout=0, resp=0; counter-- ; at 0 -> DATA.
//   DATA: readyout=1, resp=0; read: rdata_out = addressed word; write: wdata_in committed with byte enables this cycle.
//   ERR1: readyout=0, resp=1 -> ERR2. ERR2: readyout=1, resp=1, rdata_out=0.
//   From DATA/ERR2 a new address phase in the same cycle is accepted (pipelining) -> next state as from IDLE; else -> IDLE.
//  Latency: OKAY data phase = WAIT_STATES+1 cycles; ERROR = 2 cycles.
//  Byte lanes: lane mask = ((1<<(1<<size))-1) << addr[log2(bytes)-1:0]; unselected write lanes unchanged;
//   read returns full word (all lanes), master extracts.
//  RAW hazard: read whose address phase overlaps a write data phase to same word returns post-write data (bypass per lane).
//  Read data for non-read phases: rdata_out holds last value (don't-care to master).
// STRUCTURE
//  Shared include ahb_defines.vh: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE codes, RESP_OKAY/RESP_ERROR, FSM state encodings.
//  Sub-module ahb_sram_bytemem: MEM_DEPTH x AHB_DATA_WIDTH, per-byte write enables, synchronous write, async read.
//  Top: address-phase capture regs, error check, FSM + wait counter, bypass mux, output regs.
// TESTING
//  Reset: hold ahb_rst_in 2 cycles mid-WAIT of a write to 0x04 -> readyout=1, resp=0, rdata=0; read 0x04 later != that wdata.
//  Word write/read, WAIT_STATES=1: write 0x10=0xDEADBEEF then read 0x10 -> readyout 0,1 per phase; rdata=0xDEADBEEF, resp=0.
//  Byte lanes: word 0x20=0x11223344, write byte 0x21=0xAA (size 0) -> read 0x20 = 0x1122AA44.
//  Errors: read 0x02 size 2 (unaligned), then addr 0x100 (out of range) -> each: readyout 0/resp 1, then readyout 1/resp 1; SRAM unchanged.
//  Pipelined back-to-back, WAIT_STATES=0: NONSEQ write 0x08=0xCAFEF00D, SEQ read 0x08 next cycle -> rdata=0xCAFEF00D (bypass), no stall.
//  IDLE/BUSY/unselected: trans=01 or sel=0 -> readyout=1, resp=0 every cycle, no SRAM change.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared definitions for the AHB-Lite SRAM responder: transfer/size/response
// codes and the data-phase FSM state encoding.
package ahb_sram_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   // State names describe the data phase currently presented on the bus.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Word-organised SRAM with one write enable per byte lane.
// Write is synchronous, read is combinational so the top can register it.
module ahb_sram_bytemem #(
   parameter int DEPTH = 64,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [DW/8-1:0]          wr_be,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic [DW-1:0]            wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [DW-1:0]            rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Commit only the enabled byte lanes of the addressed word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DW/8; i++) begin
         if (wr_en && wr_be[i]) begin
            mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by an internal byte-lane SRAM.
// Captures the address phase, checks it, sequences WAIT/DATA or the
// two-cycle ERROR response and drives registered rdata/readyout/resp.
module ahb_sram_slave
   import ahb_sram_slave_pkg::*;
#(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32,
   parameter int MEM_DEPTH      = 64,
   parameter int WAIT_STATES    = 1
) (
   input  logic                      ahb_clk_in,
   input  logic                      ahb_rst_in,
   input  logic                      ahb_sel_in,
   input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
   input  logic [1:0]                ahb_trans_in,
   input  logic                      ahb_write_in,
   input  logic [2:0]                ahb_size_in,
   input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
   input  logic                      ahb_ready_in,
   output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
   output logic                      ahb_readyout_out,
   output logic                      ahb_resp_out
);

   localparam int BYTES = AHB_DATA_WIDTH / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int IDXW  = $clog2(MEM_DEPTH);
   localparam logic [AHB_ADDR_WIDTH-1:0] MEM_BYTES = AHB_ADDR_WIDTH'(MEM_DEPTH * BYTES);
   localparam logic [2:0] MAX_SIZE = 3'(OFFW);
   localparam logic [3:0] WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   // Byte lanes touched by a transfer of the given size at the given offset.
   function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size, input logic [OFFW-1:0] off);
      logic [BYTES-1:0] m;
      int lo;
      int hi;
      m  = '0;
      lo = int'(off);
      hi = lo + (1 << int'(size));
      for (int i = 0; i < BYTES; i++) begin
         m[i] = (i >= lo) && (i < hi);
      end
      return m;
   endfunction

   // Offset bits that must be zero for a transfer of the given size.
   function automatic logic misaligned(input logic [2:0] size, input logic [OFFW-1:0] off);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < OFFW; i++) begin
         if ((i < int'(size)) && off[i]) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [3:0]          wait_cnt_r;
   logic [3:0]          cnt_nxt_s;

   logic                cap_write_r;
   logic [IDXW-1:0]     cap_idx_r;
   logic [BYTES-1:0]    cap_lanes_r;

   logic                trans_active_s;
   logic                accept_s;
   logic                err_s;
   logic [IDXW-1:0]     in_idx_s;
   logic [BYTES-1:0]    in_lanes_s;

   logic                rd_write_s;
   logic [IDXW-1:0]     rd_idx_s;
   logic [AHB_DATA_WIDTH-1:0] mem_rdata_s;
   logic [AHB_DATA_WIDTH-1:0] rd_word_s;
   logic                mem_we_s;

   logic [AHB_DATA_WIDTH-1:0] rdata_r;
   logic                readyout_r;
   logic                resp_r;

   assign trans_active_s = (ahb_trans_in == HTRANS_NONSEQ) || (ahb_trans_in == HTRANS_SEQ);
   assign accept_s = ahb_sel_in && ahb_ready_in && trans_active_s &&
                     ((state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2));
   assign in_idx_s   = ahb_addr_in[OFFW +: IDXW];
   assign in_lanes_s = lane_mask(ahb_size_in, ahb_addr_in[OFFW-1:0]);

   // Address-phase legality: size fits the bus, naturally aligned, inside the SRAM window.
   always_comb begin
      err_s = 1'b0;
      if (ahb_size_in > MAX_SIZE) begin
         err_s = 1'b1;
      end else if (misaligned(ahb_size_in, ahb_addr_in[OFFW-1:0])) begin
         err_s = 1'b1;
      end else if (ahb_addr_in >= MEM_BYTES) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
   end

   // Next data-phase state and wait counter.
   always_comb begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = wait_cnt_r;
      case (state_r)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (accept_s) begin
               if (err_s) begin
                  state_nxt_s = ST_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_nxt_s = ST_DATA;
               end else begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = WS_LOAD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == 4'd0) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = wait_cnt_r - 4'd1;
            end
         end
         ST_ERR1: begin
            state_nxt_s = ST_ERR2;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge ahb_clk_in) begin
      if (ahb_rst_in) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 4'd0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= cnt_nxt_s;
      end
   end

   // Capture the accepted address phase for use in its data phase.
   always_ff @(posedge ahb_clk_in) begin
      if (ahb_rst_in) begin
         cap_write_r <= 1'b0;
         cap_idx_r   <= '0;
         cap_lanes_r <= '0;
      end else if (accept_s) begin
         cap_write_r <= ahb_write_in;
         cap_idx_r   <= in_idx_s;
         cap_lanes_r <= in_lanes_s;
      end
   end

   // A write commits at the end of its DATA cycle, never under reset.
   assign mem_we_s = (state_r == ST_DATA) && cap_write_r && !ahb_rst_in;

   // The transfer about to enter DATA comes from the capture regs after a
   // wait, or straight from the bus when it enters DATA without waiting.
   assign rd_write_s = (state_r == ST_WAIT) ? cap_write_r : ahb_write_in;
   assign rd_idx_s   = (state_r == ST_WAIT) ? cap_idx_r : in_idx_s;

   ahb_sram_bytemem #(
      .DEPTH (MEM_DEPTH),
      .DW    (AHB_DATA_WIDTH)
   ) u_mem (
      .clk     (ahb_clk_in),
      .wr_en   (mem_we_s),
      .wr_be   (cap_lanes_r),
      .wr_idx  (cap_idx_r),
      .wr_data (ahb_wdata_in),
      .rd_idx  (rd_idx_s),
      .rd_data (mem_rdata_s)
   );

   // Forward lanes being written this cycle to a read of the same word.
   always_comb begin
      rd_word_s = mem_rdata_s;
      for (int i = 0; i < BYTES; i++) begin
         if (mem_we_s && (cap_idx_r == rd_idx_s) && cap_lanes_r[i]) begin
            rd_word_s[8*i +: 8] = ahb_wdata_in[8*i +: 8];
         end else begin
            rd_word_s[8*i +: 8] = mem_rdata_s[8*i +: 8];
         end
      end
   end

   // Registered bus outputs, aligned with the state being entered.
   always_ff @(posedge ahb_clk_in) begin
      if (ahb_rst_in) begin
         rdata_r    <= '0;
         readyout_r <= 1'b1;
         resp_r     <= RESP_OKAY;
      end else begin
         readyout_r <= !((state_nxt_s == ST_WAIT) || (state_nxt_s == ST_ERR1));
         resp_r     <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
         if (state_nxt_s == ST_ERR2) begin
            rdata_r <= '0;
         end else if ((state_nxt_s == ST_DATA) && !rd_write_s) begin
            rdata_r <= rd_word_s;
         end
      end
   end

   assign ahb_rdata_out    = rdata_r;
   assign ahb_readyout_out = readyout_r;
   assign ahb_resp_out     = resp_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with one wait state, one with none.
// A driver walks a table of transfers and pushes expected responses; a
// monitor pops and compares whenever the selected slave completes a phase.
module tb_ahb_sram_slave;
   import ahb_sram_slave_pkg::*;

   typedef struct {
      bit          sel;
      logic [1:0]  trans;
      bit          write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          is_err;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      bit          is_err;
      bit          is_read;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [1:0]  trans = HTRANS_IDLE;
   logic        write = 1'b0;
   logic [2:0]  size = HSIZE_WORD;
   logic [31:0] wdata = 32'd0;
   bit          which = 1'b0;

   logic [31:0] rdata0, rdata1;
   logic        ro0, ro1, resp0, resp1;
   logic        sel0, sel1;

   assign sel0 = sel && !which;
   assign sel1 = sel && which;

   ahb_sram_slave #(.WAIT_STATES(1)) u_dut_ws1 (
      .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel0), .ahb_addr_in(addr),
      .ahb_trans_in(trans), .ahb_write_in(write), .ahb_size_in(size),
      .ahb_wdata_in(wdata), .ahb_ready_in(ro0), .ahb_rdata_out(rdata0),
      .ahb_readyout_out(ro0), .ahb_resp_out(resp0)
   );

   ahb_sram_slave #(.WAIT_STATES(0)) u_dut_ws0 (
      .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel1), .ahb_addr_in(addr),
      .ahb_trans_in(trans), .ahb_write_in(write), .ahb_size_in(size),
      .ahb_wdata_in(wdata), .ahb_ready_in(ro1), .ahb_rdata_out(rdata1),
      .ahb_readyout_out(ro1), .ahb_resp_out(resp1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   xfer_t q[$];
   exp_t  sb[$];

   logic        rdy_m, resp_m;
   logic [31:0] rdata_m;
   assign rdy_m   = which ? ro1 : ro0;
   assign resp_m  = which ? resp1 : resp0;
   assign rdata_m = which ? rdata1 : rdata0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: tracks the active data phase and scores each completion.
   bit pending = 1'b0;
   int waits   = 0;
   always @(negedge clk) begin
      if (rst) begin
         pending = 1'b0;
         waits   = 0;
      end else begin
         if (pending) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
               pending = 1'b0;
            end else if (rdy_m) begin
               exp_t e;
               e = sb.pop_front();
               chk("resp", {31'd0, resp_m}, {31'd0, e.is_err});
               chk("wait_cycles", waits, e.waits);
               if (e.is_err) begin
                  chk("err_rdata", rdata_m, 32'd0);
               end else if (e.is_read) begin
                  chk("rdata", rdata_m, e.rdata);
               end
               pending = 1'b0;
            end else begin
               chk("stall_resp", {31'd0, resp_m}, {31'd0, sb[0].is_err});
               waits++;
            end
         end else begin
            chk("idle_ready", {31'd0, rdy_m}, 32'd1);
            chk("idle_resp", {31'd0, resp_m}, 32'd0);
         end
         if (rdy_m && sel && trans[1]) begin
            pending = 1'b1;
            waits   = 0;
         end
      end
   end

   task automatic add(input bit s, input logic [1:0] t, input bit w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input bit er, input logic [31:0] rd);
      xfer_t x;
      x.sel = s; x.trans = t; x.write = w; x.size = sz;
      x.addr = a; x.wdata = wd; x.is_err = er; x.rdata = rd;
      q.push_back(x);
   endtask

   // Issue every queued transfer, pipelining address and data phases.
   task automatic run_queue();
      int    idx = 0;
      bit    have_dp = 1'b0;
      xfer_t dp;
      logic  rdy;
      int    guard = 0;
      while ((idx < q.size()) || have_dp) begin
         if (idx < q.size()) begin
            sel = q[idx].sel; trans = q[idx].trans; write = q[idx].write;
            size = q[idx].size; addr = q[idx].addr;
         end else begin
            sel = 1'b0; trans = HTRANS_IDLE; write = 1'b0; addr = 32'd0;
         end
         wdata = (have_dp && dp.write) ? dp.wdata : 32'd0;
         @(negedge clk);
         rdy = rdy_m;
         @(posedge clk);
         #1;
         guard++;
         if (guard > 200) begin
            chk("run_timeout", 32'd1, 32'd0);
            break;
         end
         if (rdy) begin
            have_dp = 1'b0;
            if (idx < q.size()) begin
               if (q[idx].sel && q[idx].trans[1]) begin
                  exp_t e;
                  have_dp   = 1'b1;
                  dp        = q[idx];
                  e.is_err  = q[idx].is_err;
                  e.is_read = !q[idx].write;
                  e.rdata   = q[idx].rdata;
                  e.waits   = q[idx].is_err ? 1 : (which ? 0 : 1);
                  sb.push_back(e);
               end
               idx++;
            end
         end
      end
      sel = 1'b0; trans = HTRANS_IDLE; write = 1'b0; wdata = 32'd0; addr = 32'd0;
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_ready0", {31'd0, ro0}, 32'd1);
      chk("rst_resp0", {31'd0, resp0}, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      @(posedge clk); #1;

      // Known content at 0x04, then a write to it aborted by reset mid-WAIT.
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h04, 32'h0BADC0DE, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h04, 32'h0, 0, 32'h0BADC0DE);
      run_queue();
      sel = 1'b1; trans = HTRANS_NONSEQ; write = 1'b1; size = HSIZE_WORD; addr = 32'h04;
      @(posedge clk); #1;
      sel = 1'b0; trans = HTRANS_IDLE; write = 1'b0; wdata = 32'h55555555; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; wdata = 32'd0;
      @(negedge clk);
      chk("midrst_rdata", rdata0, 32'd0);
      chk("midrst_ready", {31'd0, ro0}, 32'd1);
      chk("midrst_resp", {31'd0, resp0}, 32'd0);
      @(posedge clk); #1;
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h04, 32'h0, 0, 32'h0BADC0DE);

      // Word write/read and byte/half lanes.
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0, 32'hDEADBEEF);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h11223344, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h21, 32'hAAAAAAAA, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0, 0, 32'h1122AA44);
      add(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h22, 32'h55667788, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0, 0, 32'h5566AA44);

      // Errors: unaligned, out of range, oversize; errored writes leave SRAM alone.
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h00, 32'h01020304, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h02, 32'h0, 1, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h100, 32'h0, 1, 32'h0);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h100, 32'hFFFFFFFF, 1, 32'h0);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h12, 32'h00000000, 1, 32'h0);
      add(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 32'h18, 32'h0, 1, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h00, 32'h0, 0, 32'h01020304);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0, 32'hDEADBEEF);

      // IDLE/BUSY/unselected cycles must not touch the SRAM.
      add(1, HTRANS_BUSY, 1, HSIZE_WORD, 32'h10, 32'h0, 0, 32'h0);
      add(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'h0, 0, 32'h0);
      add(1, HTRANS_IDLE, 1, HSIZE_WORD, 32'h10, 32'h0, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0, 32'hDEADBEEF);
      run_queue();

      // Zero-wait instance: pipelined write-then-read bypass.
      which = 1'b1;
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h08, 32'hCAFEF00D, 0, 32'h0);
      add(1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h08, 32'h0, 0, 32'hCAFEF00D);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0C, 32'h12345678, 0, 32'h0);
      add(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h0F, 32'h9A000000, 0, 32'h0);
      add(1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h0C, 32'h0, 0, 32'h9A345678);
      add(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h03, 32'h0, 1, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h08, 32'h0, 0, 32'hCAFEF00D);
      run_queue();

      repeat (2) @(posedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
